// File: rtl/tape_mic_recorder_if.sv
// tape_mic_recorder_if: SDRAM tape write port with toggle-acknowledge handshake
interface tape_mic_recorder_if;
    logic [22:0] tape_addr;
    logic [7:0]  tape_din;
    logic        tape_wr;
    logic        tape_ack;
    modport master (output tape_addr, output tape_din, output tape_wr, input tape_ack);
    modport slave  (input tape_addr, input tape_din, input tape_wr, output tape_ack);
endinterface

// File: rtl/tape_mic_recorder.sv
// tape_mic_recorder: turns MIC half-periods into TAP blocks written to the SDRAM tape buffer
module tape_mic_recorder #(
    parameter logic [9:0]  PILOT_MIN   = 10'd256,
    parameter logic [15:0] T_NOISE     = 16'd400,
    parameter logic [15:0] T_SHORT_MAX = 16'd1200,
    parameter logic [15:0] T_LONG_MAX  = 16'd1950,
    parameter logic [15:0] T_PILOT_MAX = 16'd2600,
    parameter logic [15:0] T_TIMEOUT   = 16'd65535,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ce_3m5,
    input  logic                arm,
    input  logic                mic,
    tape_mic_recorder_if.master tape,
    output logic [22:0]         rec_end,
    output logic [7:0]          blocks,
    output logic                recording,
    output logic                err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, SYNC2 = 3'd1, DATA_A = 3'd2, DATA_B = 3'd3;
    localparam logic [2:0] FINAL = 3'd4, HDR_LO = 3'd5, HDR_HI = 3'd6;
    localparam logic [1:0] C_SHORT = 2'd0, C_LONG = 2'd1, C_PILOT = 2'd2, C_INVALID = 2'd3;

    logic mic_s1, mic_s2, mic_prev, arm_d, arm_rise;
    logic [15:0] cnt, cnt_inc;
    logic mic_edge, half, timeout;
    logic [1:0] cls;
    logic [2:0] state, bitcnt;
    logic [9:0] pcnt;
    logic [6:0] sr;
    logic a_long;
    logic [15:0] len, widx;
    logic [22:0] base, next_base, addr;
    logic [7:0] din, new_byte;
    logic wr, ack_last, ack_seen;
    logic [AW-1:0] wp, rp;
    logic [AW:0] fill;
    logic [7:0] mem [FIFO_DEPTH];
    logic full, empty, byte_done, push, drop, pop;

    assign tape.tape_addr = addr;
    assign tape.tape_din  = din;
    assign tape.tape_wr   = wr;
    assign arm_rise  = arm && !arm_d;
    assign recording = (state == SYNC2) || (state == DATA_A) || (state == DATA_B);
    assign full      = (fill == (AW+1)'(FIFO_DEPTH));
    assign empty     = (fill == '0);
    assign new_byte  = {sr, a_long};
    assign next_base = base + 23'd2 + {7'd0, len};
    assign ack_seen  = wr && (tape.tape_ack != ack_last);
    assign byte_done = half && arm && (state == DATA_B) && (cls == {1'b0, a_long}) && (bitcnt == 3'd7);
    assign push      = byte_done && !full && (len != 16'hFFFF);
    assign drop      = byte_done && !push;
    assign pop       = !wr && !empty && (state != HDR_LO) && (state != HDR_HI);

    // Half-period width with saturation, edge qualification and pulse classification
    always_comb begin
        cnt_inc  = (cnt == T_TIMEOUT) ? cnt : cnt + 16'd1;
        mic_edge = ce_3m5 && (mic_s2 != mic_prev);
        half     = mic_edge && (cnt_inc >= T_NOISE);
        timeout  = (cnt == T_TIMEOUT);
        cls      = (cnt_inc <= T_SHORT_MAX) ? C_SHORT :
                   (cnt_inc <= T_LONG_MAX)  ? C_LONG  :
                   (cnt_inc <= T_PILOT_MAX) ? C_PILOT : C_INVALID;
    end

    // MIC synchronizer and T-state width counter; glitches leave the count running
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            mic_s1   <= 1'b0;
            mic_s2   <= 1'b0;
            mic_prev <= 1'b0;
            arm_d    <= 1'b0;
            cnt      <= '0;
        end else begin
            mic_s1 <= mic;
            mic_s2 <= mic_s1;
            arm_d  <= arm;
            if (arm_rise)
                cnt <= '0;
            else if (ce_3m5) begin
                mic_prev <= mic_s2;
                cnt      <= half ? 16'd0 : cnt_inc;
            end
        end
    end

    // Byte FIFO storage
    always_ff @(posedge clk_sys) begin
        if (push) mem[wp] <= new_byte;
    end

    // Block FSM, FIFO pointers and the SDRAM writer (headers are patched after the data)
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= IDLE;
            pcnt     <= '0;
            bitcnt   <= '0;
            sr       <= '0;
            a_long   <= 1'b0;
            len      <= '0;
            widx     <= '0;
            base     <= '0;
            rec_end  <= '0;
            blocks   <= '0;
            err      <= 1'b0;
            wr       <= 1'b0;
            ack_last <= tape.tape_ack;
            addr     <= '0;
            din      <= '0;
            wp       <= '0;
            rp       <= '0;
            fill     <= '0;
        end else if (arm_rise) begin
            state   <= IDLE;
            pcnt    <= '0;
            bitcnt  <= '0;
            len     <= '0;
            widx    <= '0;
            base    <= '0;
            rec_end <= '0;
            blocks  <= '0;
            err     <= 1'b0;
            wp      <= '0;
            rp      <= '0;
            fill    <= '0;
            if (ack_seen) begin
                wr       <= 1'b0;
                ack_last <= tape.tape_ack;
            end
        end else begin
            if (ack_seen) begin
                wr       <= 1'b0;
                ack_last <= tape.tape_ack;
            end else if (!wr && state == HDR_LO) begin
                addr  <= base;
                din   <= len[7:0];
                wr    <= 1'b1;
                state <= HDR_HI;
            end else if (!wr && state == HDR_HI) begin
                addr    <= base + 23'd1;
                din     <= len[15:8];
                wr      <= 1'b1;
                base    <= next_base;
                rec_end <= next_base;
                blocks  <= blocks + 8'd1;
                state   <= IDLE;
            end else if (pop) begin
                addr <= base + 23'd2 + {7'd0, widx};
                din  <= mem[rp];
                wr   <= 1'b1;
                rp   <= rp + AW'(1);
                widx <= widx + 16'd1;
            end
            fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
            if (push) begin
                wp  <= wp + AW'(1);
                len <= len + 16'd1;
            end
            if (drop) err <= 1'b1;
            case (state)
                IDLE: if (arm && half) begin
                    pcnt <= (cls != C_PILOT) ? 10'd0 : (pcnt == 10'h3FF) ? pcnt : pcnt + 10'd1;
                    if (cls == C_SHORT && pcnt >= PILOT_MIN) begin
                        state <= SYNC2;
                        len   <= '0;
                        widx  <= '0;
                    end
                end
                SYNC2: if (!arm) state <= FINAL;
                    else if (half) begin
                        state  <= (cls == C_SHORT) ? DATA_A : IDLE;
                        bitcnt <= '0;
                    end else if (timeout) state <= IDLE;
                DATA_A: if (!arm) state <= FINAL;
                    else if (half) begin
                        a_long <= (cls == C_LONG);
                        state  <= (cls == C_SHORT || cls == C_LONG) ? DATA_B : FINAL;
                    end else if (timeout) state <= FINAL;
                DATA_B: if (!arm) state <= FINAL;
                    else if (half) begin
                        if (cls == {1'b0, a_long}) begin
                            sr     <= new_byte[6:0];
                            bitcnt <= bitcnt + 3'd1;
                            state  <= DATA_A;
                        end else state <= FINAL;
                    end else if (timeout) state <= FINAL;
                FINAL: if (len == 16'd0) state <= IDLE;
                    else if (empty && !wr) state <= HDR_LO;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tape_mic_recorder.sv
// tb_tape_mic_recorder: directed TAP recording scenarios against a block-level write model
module tb_tape_mic_recorder;
    // timings scaled by 1/32 so the whole run stays short
    localparam int PIL = 68, S1 = 21, S2 = 23, B0 = 27, B1 = 53, SIL = 600, DEPTH = 4;

    logic clk_sys = 1'b0, reset_n = 1'b0, ce_3m5 = 1'b0, arm = 1'b0, mic = 1'b0;
    logic [22:0] rec_end;
    logic [7:0] blocks;
    logic recording, err;
    tape_mic_recorder_if tif();

    tape_mic_recorder #(
        .PILOT_MIN(10'd16), .T_NOISE(16'd12), .T_SHORT_MAX(16'd37), .T_LONG_MAX(16'd61),
        .T_PILOT_MAX(16'd81), .T_TIMEOUT(16'd500), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_3m5(ce_3m5), .arm(arm), .mic(mic),
        .tape(tif), .rec_end(rec_end), .blocks(blocks), .recording(recording), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0, bad = 0, ce_cyc = 0, nwrites = 0, dly = 0;
    int m_base = 0, m_blocks = 0, m_err = 0;
    logic [22:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic [7:0] blk[$];
    logic [7:0] sdram [64];
    logic [22:0] cur_a;
    logic [7:0] cur_d;
    bit busy = 0, acked = 0, stall = 0;

    // T-state enable with one idle slot in every eight clocks
    always @(negedge clk_sys) begin
        ce_cyc++;
        ce_3m5 = (ce_cyc % 8) != 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // SDRAM responder and per-cycle compare against the expected write stream
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            busy = 0;
            acked = 0;
        end else if (tif.tape_wr) begin
            if (!busy) begin
                busy = 1;
                acked = 0;
                dly = 3;
                cur_a = tif.tape_addr;
                cur_d = tif.tape_din;
                nwrites++;
                sdram[cur_a[5:0]] = cur_d;
                if (exp_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h at %0h required none", cur_d, cur_a);
                end else begin
                    chk("wr_addr", cur_a, exp_a.pop_front());
                    chk("wr_data", cur_d, exp_d.pop_front());
                end
            end else begin
                chk("wr_hold_addr", tif.tape_addr, cur_a);
                chk("wr_hold_data", tif.tape_din, cur_d);
                if (acked) begin
                    total++;
                    bad++;
                    $display("FAIL wr_drop: got tape_wr=1 after ack, required 0");
                end else if (!stall) begin
                    if (dly == 0) begin
                        tif.tape_ack = ~tif.tape_ack;
                        acked = 1;
                    end else dly--;
                end
            end
        end else busy = 0;
    end

    // Block-level model: data bytes after the 2-byte header slot, header patched last
    task automatic model_block(input int keep);
        for (int i = 0; i < keep; i++) begin
            exp_a.push_back(23'(m_base + 2 + i));
            exp_d.push_back(blk[i]);
        end
        exp_a.push_back(23'(m_base));
        exp_d.push_back(keep[7:0]);
        exp_a.push_back(23'(m_base + 1));
        exp_d.push_back(keep[15:8]);
        m_base += 2 + keep;
        m_blocks++;
    endtask

    task automatic wait_t(input int t);
        int n = 0;
        while (n < t) begin
            @(posedge clk_sys);
            if (ce_3m5) n++;
        end
    endtask

    task automatic tog();
        @(negedge clk_sys);
        mic = ~mic;
    endtask

    task automatic hp(input int t);
        tog();
        wait_t(t);
    endtask

    task automatic lead(input int npil, input int gl);
        for (int i = 0; i < npil; i++) begin
            if (i == gl) begin
                tog(); wait_t(6); tog(); wait_t(3); tog(); wait_t(PIL - 9);
            end else hp(PIL);
        end
        hp(S1);
        hp(S2);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] v;
            v = blk[i];
            for (int b = 7; b >= 0; b--) begin
                hp(v[b] ? B1 : B0);
                hp(v[b] ? B1 : B0);
            end
        end
    endtask

    task automatic close_block();
        tog();
        wait_t(SIL);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || tif.tape_wr) && n < 4000) begin
            @(posedge clk_sys);
            n++;
        end
        @(negedge clk_sys);
        chk("drain_pending", exp_a.size(), 0);
    endtask

    task automatic chk_model();
        chk("rec_end", rec_end, m_base);
        chk("blocks", blocks, m_blocks);
        chk("err", err, m_err);
    endtask

    task automatic rearm();
        @(negedge clk_sys);
        arm = 0;
        repeat (3) @(negedge clk_sys);
        arm = 1;
        m_base = 0;
        m_blocks = 0;
        m_err = 0;
        for (int i = 0; i < 64; i++) sdram[i] = 8'hEE;
        wait_t(SIL);
    endtask

    initial begin
        int n0, nrec;
        tif.tape_ack = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("rst_wr", tif.tape_wr, 0);
        chk("rst_addr", tif.tape_addr, 0);
        chk("rst_din", tif.tape_din, 0);
        chk("rst_rec_end", rec_end, 0);
        chk("rst_blocks", blocks, 0);
        chk("rst_recording", recording, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;

        // header-style block: 0x00, 0xA5, 0x13
        rearm();
        blk = '{8'h00, 8'hA5, 8'h13};
        model_block(3);
        lead(19, -1);
        send_bytes(3);
        close_block();
        drain();
        chk_model();
        chk("t1_mem0", sdram[0], 8'h03);
        chk("t1_mem1", sdram[1], 8'h00);
        chk("t1_mem2", sdram[2], 8'h00);
        chk("t1_mem3", sdram[3], 8'hA5);
        chk("t1_mem4", sdram[4], 8'h13);
        chk("t1_rec_end", rec_end, 5);
        chk("t1_blocks", blocks, 1);

        // two consecutive blocks of 2 and 1 bytes
        rearm();
        blk = '{8'h3C, 8'hFF};
        model_block(2);
        lead(19, -1);
        send_bytes(2);
        close_block();
        drain();
        blk = '{8'h81};
        model_block(1);
        lead(19, -1);
        send_bytes(1);
        close_block();
        drain();
        chk_model();
        chk("t2_hdr_lo", sdram[4], 8'h01);
        chk("t2_hdr_hi", sdram[5], 8'h00);
        chk("t2_data", sdram[6], 8'h81);
        chk("t2_rec_end", rec_end, 7);
        chk("t2_blocks", blocks, 2);

        // short pilot: nothing may be recorded
        blk = '{8'h55};
        lead(12, -1);
        send_bytes(1);
        close_block();
        drain();
        chk("t3_blocks", blocks, 2);
        chk("t3_rec_end", rec_end, 7);
        chk("t3_recording", recording, 0);

        // glitch inside a pilot half with the pilot count exactly at the minimum
        rearm();
        blk = '{8'h5A};
        model_block(1);
        lead(16, 4);
        send_bytes(1);
        close_block();
        drain();
        chk_model();
        chk("t4_hdr", sdram[0], 8'h01);
        chk("t4_data", sdram[2], 8'h5A);

        // stalled SDRAM: one byte in the write register plus a full FIFO survive
        rearm();
        blk = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        model_block(DEPTH + 1);
        m_err = 1;
        stall = 1;
        n0 = nwrites;
        lead(19, -1);
        send_bytes(8);
        close_block();
        chk("t5_err_stalled", err, 1);
        chk("t5_rec_end_stalled", rec_end, 0);
        stall = 0;
        drain();
        chk_model();
        nrec = nwrites - n0 - 2;
        chk("t5_hdr", sdram[0], 8'h05);
        chk("t5_len_vs_kept", sdram[0], nrec);

        // mismatched halves mid-byte after three good bytes
        rearm();
        blk = '{8'hC3, 8'h01, 8'h7E};
        model_block(3);
        lead(19, -1);
        send_bytes(3);
        hp(B1); hp(B1); hp(B0); hp(B1);
        @(negedge clk_sys);
        chk("t6_recording_before", recording, 1);
        tog();
        for (int i = 0; i < 10 && recording; i++) @(negedge clk_sys);
        chk("t6_recording_fall", recording, 0);
        wait_t(SIL);
        drain();
        chk_model();
        chk("t6_hdr", sdram[0], 8'h03);
        chk("t6_rec_end", rec_end, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end
endmodule
